reg_dump_ctrl: RTL and testbench
================================

# reg_dump_ctrl

Sequential read-out engine for the single-cycle CPU register file. On a `start` pulse it walks register indices `FIRST_REG` through `LAST_REG` on one register-file read port and streams each (index, value) pair out over a valid/ready handshake. While it runs it holds the CPU so the snapshot is consistent. It sits between the register file's second read port (muxed in while `busy`) and the debug/trace path of the testbench or host.

## Interface
- `FIRST_REG`, default 0: first index dumped.
- `LAST_REG`, default 31: last index dumped. `FIRST_REG` ≤ `LAST_REG` ≤ 31 is an elaboration-time check.
- `clk` input 1: single clock. All state updates on posedge.
- `rst_n` input 1: reset, synchronous, active-low.
- `start` input 1: one-cycle request to begin a dump. Sampled only in IDLE.
- `abort` input 1: synchronous cancel of a running dump.
- `rn` output 5: read index driven to the register-file read port.
- `rd_data` input 32: combinational read data for `rn`. Valid in the same cycle.
- `cpu_hold` output 1: stalls the PC and register-file write enable while high.
- `busy` output 1: high in any state other than IDLE.
- `done` output 1: one-cycle pulse after the last pair is accepted.
- `out_valid` output 1: an (index, value) pair is presented.
- `out_ready` input 1: the consumer accepts the pair when `out_valid && out_ready`.
- `out_idx` output 5: register index of the presented pair.
- `out_data` output 32: register value of the presented pair.

## Operation
- States are IDLE, FETCH, SEND and DONE.
- **IDLE**
  - `rn`=0; all outputs 0.
  - `start` → FETCH; the index counter loads `FIRST_REG`.
- **FETCH** (one cycle)
  - `rn`=counter; `cpu_hold`=1.
  - At the clock edge, `rd_data` is captured into `out_data` and the counter into `out_idx`. Go to SEND.
- **SEND**
  - `out_valid`=1. `out_idx` and `out_data` stay stable until acceptance.
  - On acceptance:
    - If counter = `LAST_REG` → DONE.
    - Otherwise the counter increments → FETCH.
- **DONE** (one cycle)
  - `done`=1, `cpu_hold`=1 → IDLE.
- `cpu_hold`=`busy`. Asserting it in DONE guarantees no CPU write lands before the dump is reported complete.
- Index 0 is read like any other index. The register file returns 0 for it, and that 0 is forwarded unchanged.
- The counter is 5-bit and never wraps: termination compares against `LAST_REG` before incrementing. `LAST_REG`=31 must not wrap the counter to 0.
- `abort` has priority over every other event in FETCH, SEND and DONE:
  - The next state is IDLE. `out_valid` drops the next cycle, even if it was not yet accepted.
  - No `done` pulse is produced.
  - `abort` in IDLE is ignored.
- `start` while `busy` is ignored.
- If `start` and `abort` are high together in IDLE, the dump starts.
- Reset mid-dump: next state IDLE, all outputs 0, no `done`.

## Timing
- Reset values:
  - `rn`=0, `cpu_hold`=0, `busy`=0, `done`=0, `out_valid`=0, `out_idx`=0, `out_data`=0.
  - State IDLE, counter 0.
- `start` sampled at edge t → FETCH during cycle t+1 → `out_valid` first high in cycle t+2.
- Each register costs 1 FETCH cycle plus at least 1 SEND cycle. With `out_ready` held high a full 0..31 dump takes 64 cycles from FETCH entry to the last acceptance. DONE follows one cycle later.
- `out_ready` may be high before `out_valid`; this has no effect outside SEND.
- Back-pressure of any length holds SEND with all outputs frozen.
- `busy` and `cpu_hold` rise in the cycle after `start` and fall in the cycle after DONE.

## Structure
- The shared package `cpu_pkg` holds `REG_ADDR_W`=5, `DATA_W`=32 and the state enum `dump_state_t` (IDLE, FETCH, SEND, DONE). The register file and datapath also import the two width constants.
- No sub-module. The FSM, index counter and output holding register are inline.
- The read-port mux that selects `rn` over the CPU's RN2 while `busy` belongs in the datapath top, not in this block.

## Test plan
- Reset and full dump:
  - Stimulus: register file preloaded with reg k = 0x100+k; `out_ready`=1; `start` pulse.
  - Required: 32 pairs in order, (0, 0) first, then (1, 0x101) … (31, 0x11F).
  - Required: one pair every 2 cycles, `done` exactly once 1 cycle after the last acceptance, `busy` low afterwards.
- Back-pressure:
  - Stimulus: `out_ready` low for 5 cycles while the pair (3, 0x103) is presented.
  - Required: `out_idx`/`out_data` stable for all 5 cycles, `rn` unchanged, no FETCH. Resumes at (4, 0x104) after acceptance.
- Window and termination:
  - Stimulus: `FIRST_REG`=29, `LAST_REG`=31.
  - Required: exactly 3 pairs, (29, 0x11D), (30, 0x11E), (31, 0x11F), then `done`; no pair for index 0 (no counter wrap).
- Abort:
  - Stimulus: `abort` while (10, 0x10A) is presented and unaccepted.
  - Required: `out_valid` 0 next cycle, no `done`, `cpu_hold` 0, state IDLE.
  - Stimulus: a following `start`.
  - Required: the dump restarts at `FIRST_REG`.
- Collisions and reset:
  - Stimulus: `start` during SEND.
  - Required: ignored, sequence unaffected.
  - Stimulus: `rst_n` low for 1 cycle mid-dump.
  - Required: all outputs 0 next cycle, no `done`.
- Hold consistency:
  - Stimulus: the CPU attempts writes to reg 5 throughout the dump.
  - Required: `cpu_hold` high from FETCH entry through DONE. The dumped value for reg 5 equals its pre-start value 0x105.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants and the register-dump state encoding.
package cpu_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned DATA_W     = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } dump_state_t;

endpackage

// File: rtl/reg_dump_ctrl.sv
// Register-file dump engine: walks FIRST_REG..LAST_REG on one read port and
// streams (index, value) pairs over valid/ready while holding the CPU.
module reg_dump_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned FIRST_REG = 0,
    parameter int unsigned LAST_REG  = 31
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    output logic [REG_ADDR_W-1:0] rn,
    input  logic [DATA_W-1:0]     rd_data,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [REG_ADDR_W-1:0] out_idx,
    output logic [DATA_W-1:0]     out_data
);

    localparam logic [REG_ADDR_W-1:0] FIRST_IDX = REG_ADDR_W'(FIRST_REG);
    localparam logic [REG_ADDR_W-1:0] LAST_IDX  = REG_ADDR_W'(LAST_REG);

    // Reject an empty or out-of-range dump window at elaboration.
    if (!(FIRST_REG <= LAST_REG && LAST_REG <= 31)) begin : g_bad_window
        $error("reg_dump_ctrl: need FIRST_REG <= LAST_REG <= 31");
    end

    dump_state_t            state_q, state_d;
    logic [REG_ADDR_W-1:0]  cnt_q, cnt_d;
    logic [REG_ADDR_W-1:0]  rn_d, idx_d;
    logic [DATA_W-1:0]      data_d;
    logic                   busy_d, done_d, valid_d;

    // Next state, counter and registered-output values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = out_idx;
        data_d  = out_data;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    cnt_d   = FIRST_IDX;
                end
            end
            FETCH: begin
                state_d = SEND;
                idx_d   = cnt_q;
                data_d  = rd_data;
            end
            SEND: begin
                if (out_ready) begin
                    // Compare before incrementing so LAST_REG=31 never wraps.
                    if (cnt_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        cnt_d   = cnt_q + REG_ADDR_W'(1);
                        state_d = FETCH;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort beats every other event once a dump is running.
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
        end

        if (state_d == IDLE) begin
            cnt_d  = '0;
            idx_d  = '0;
            data_d = '0;
        end

        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
        valid_d = (state_d == SEND);
        rn_d    = (state_d == IDLE) ? '0 : cnt_d;
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rn        <= '0;
            cpu_hold  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_data  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rn        <= rn_d;
            cpu_hold  <= busy_d;
            busy      <= busy_d;
            done      <= done_d;
            out_valid <= valid_d;
            out_idx   <= idx_d;
            out_data  <= data_d;
        end
    end

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// Directed bench for reg_dump_ctrl: full dump, back-pressure, abort,
// collisions, mid-dump reset, hold consistency and a 29..31 window.
module tb_reg_dump_ctrl;
    import cpu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start_a, abort_a, out_ready_a;
    logic [4:0]  rn_a, out_idx_a;
    logic [31:0] rd_data_a, out_data_a;
    logic        cpu_hold_a, busy_a, done_a, out_valid_a;

    logic        start_b, abort_b, out_ready_b;
    logic [4:0]  rn_b, out_idx_b;
    logic [31:0] rd_data_b, out_data_b;
    logic        cpu_hold_b, busy_b, done_b, out_valid_b;

    logic        cpu_we;
    logic [31:0] regs [32];

    int tests = 0;
    int fails = 0;
    int done_cnt_a = 0;
    int done_cnt_b = 0;

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
    } pair_t;

    pair_t full_tbl [32];
    pair_t win_tbl  [3];

    reg_dump_ctrl #(.FIRST_REG(0), .LAST_REG(31)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
        .rn(rn_a), .rd_data(rd_data_a), .cpu_hold(cpu_hold_a), .busy(busy_a),
        .done(done_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
        .out_idx(out_idx_a), .out_data(out_data_a)
    );

    reg_dump_ctrl #(.FIRST_REG(29), .LAST_REG(31)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
        .rn(rn_b), .rd_data(rd_data_b), .cpu_hold(cpu_hold_b), .busy(busy_b),
        .done(done_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_idx(out_idx_b), .out_data(out_data_b)
    );

    // Register file model: reg 0 reads as zero, CPU writes to reg 5 gated by hold.
    assign rd_data_a = (rn_a == 5'd0) ? 32'h0 : regs[rn_a];
    assign rd_data_b = (rn_b == 5'd0) ? 32'h0 : regs[rn_b];

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 32; k++) regs[k] <= 32'h100 + 32'(k);
        end else if (cpu_we && !cpu_hold_a) begin
            regs[5] <= 32'hDEAD_BEEF;
        end
    end

    always @(negedge clk) begin
        if (done_a) done_cnt_a++;
        if (done_b) done_cnt_b++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_valid_a(input string name);
        int n = 0;
        while (out_valid_a !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (out_valid_a !== 1'b1) begin
            fails++;
            $display("FAIL %s: out_valid timeout, got 0 expected 1", name);
        end
    endtask

    task automatic chk_all_zero_a(input string name);
        chk({name, "_rn"},    32'(rn_a),        32'h0);
        chk({name, "_hold"},  32'(cpu_hold_a),  32'h0);
        chk({name, "_busy"},  32'(busy_a),      32'h0);
        chk({name, "_done"},  32'(done_a),      32'h0);
        chk({name, "_valid"}, 32'(out_valid_a), 32'h0);
        chk({name, "_idx"},   32'(out_idx_a),   32'h0);
        chk({name, "_data"},  out_data_a,       32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        start_a = 1'b0; abort_a = 1'b0; out_ready_a = 1'b1;
        start_b = 1'b0; abort_b = 1'b0; out_ready_b = 1'b1;
        cpu_we = 1'b0;

        for (int k = 0; k < 32; k++) begin
            full_tbl[k].idx  = 5'(k);
            full_tbl[k].data = (k == 0) ? 32'h0 : 32'h100 + 32'(k);
        end
        win_tbl[0] = '{idx: 5'd29, data: 32'h11D};
        win_tbl[1] = '{idx: 5'd30, data: 32'h11E};
        win_tbl[2] = '{idx: 5'd31, data: 32'h11F};

        // Reset state
        repeat (2) @(negedge clk);
        chk_all_zero_a("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", 32'(busy_a), 32'h0);

        // Full dump with out_ready high and CPU writing reg 5 throughout
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        cpu_we  = 1'b1;
        chk("fetch0_busy",  32'(busy_a),      32'h1);
        chk("fetch0_hold",  32'(cpu_hold_a),  32'h1);
        chk("fetch0_valid", 32'(out_valid_a), 32'h0);
        chk("fetch0_rn",    32'(rn_a),        32'h0);
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            chk($sformatf("full_valid_%0d", k), 32'(out_valid_a), 32'h1);
            chk($sformatf("full_idx_%0d", k),   32'(out_idx_a),   32'(full_tbl[k].idx));
            chk($sformatf("full_data_%0d", k),  out_data_a,       full_tbl[k].data);
            chk($sformatf("full_hold_%0d", k),  32'(cpu_hold_a),  32'h1);
            if (k < 31) begin
                @(negedge clk);
                chk($sformatf("full_fetch_valid_%0d", k), 32'(out_valid_a), 32'h0);
                chk($sformatf("full_fetch_rn_%0d", k),    32'(rn_a),        32'(k + 1));
            end
        end
        @(negedge clk);
        chk("full_done",       32'(done_a),      32'h1);
        chk("full_done_hold",  32'(cpu_hold_a),  32'h1);
        chk("full_done_valid", 32'(out_valid_a), 32'h0);
        cpu_we = 1'b0;
        @(negedge clk);
        chk("full_after_done", 32'(done_a),     32'h0);
        chk("full_after_busy", 32'(busy_a),     32'h0);
        chk("full_after_hold", 32'(cpu_hold_a), 32'h0);
        chk("full_done_count", 32'(done_cnt_a), 32'h1);
        chk("reg5_untouched",  regs[5],         32'h105);

        // Back-pressure on pair 3, then abort on unaccepted pair 10
        out_ready_a = 1'b0;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wait_valid_a($sformatf("bp_wait_%0d", k));
            chk($sformatf("bp_idx_%0d", k), 32'(out_idx_a), 32'(k));
            out_ready_a = 1'b1;
            @(negedge clk);
            out_ready_a = 1'b0;
        end
        wait_valid_a("bp_wait_3");
        chk("bp_idx_3",  32'(out_idx_a), 32'h3);
        chk("bp_data_3", out_data_a,     32'h103);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("stall_valid_%0d", c), 32'(out_valid_a), 32'h1);
            chk($sformatf("stall_idx_%0d", c),   32'(out_idx_a),   32'h3);
            chk($sformatf("stall_data_%0d", c),  out_data_a,       32'h103);
            chk($sformatf("stall_rn_%0d", c),    32'(rn_a),        32'h3);
        end
        out_ready_a = 1'b1;
        @(negedge clk);
        out_ready_a = 1'b0;
        chk("bp_fetch4_valid", 32'(out_valid_a), 32'h0);
        chk("bp_fetch4_rn",    32'(rn_a),        32'h4);
        for (int k = 4; k < 10; k++) begin
            wait_valid_a($sformatf("run_wait_%0d", k));
            chk($sformatf("run_idx_%0d", k),  32'(out_idx_a), 32'(k));
            chk($sformatf("run_data_%0d", k), out_data_a,     32'h100 + 32'(k));
            out_ready_a = 1'b1;
            @(negedge clk);
            out_ready_a = 1'b0;
        end
        wait_valid_a("abort_wait_10");
        chk("abort_idx_10",  32'(out_idx_a), 32'hA);
        chk("abort_data_10", out_data_a,     32'h10A);
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        chk("abort_valid", 32'(out_valid_a), 32'h0);
        chk("abort_done",  32'(done_a),      32'h0);
        chk("abort_hold",  32'(cpu_hold_a),  32'h0);
        chk("abort_busy",  32'(busy_a),      32'h0);
        @(negedge clk);
        chk("abort_idle_busy",  32'(busy_a),     32'h0);
        chk("abort_done_count", 32'(done_cnt_a), 32'h1);

        // Restart after abort, start collision in SEND, then reset mid-dump
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_valid_a("restart_wait");
        chk("restart_idx",  32'(out_idx_a), 32'h0);
        chk("restart_data", out_data_a,     32'h0);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        chk("collide_valid", 32'(out_valid_a), 32'h1);
        chk("collide_idx",   32'(out_idx_a),   32'h0);
        out_ready_a = 1'b1;
        @(negedge clk);
        out_ready_a = 1'b0;
        chk("collide_fetch_rn", 32'(rn_a), 32'h1);
        wait_valid_a("collide_wait_1");
        chk("collide_idx_1",  32'(out_idx_a), 32'h1);
        chk("collide_data_1", out_data_a,     32'h101);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_all_zero_a("midreset");
        @(negedge clk);
        chk("midreset_busy",       32'(busy_a),     32'h0);
        chk("midreset_done_count", 32'(done_cnt_a), 32'h1);

        // Window 29..31 on the second instance: no wrap to index 0
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        chk("win_fetch_busy",  32'(busy_b),      32'h1);
        chk("win_fetch_valid", 32'(out_valid_b), 32'h0);
        chk("win_fetch_rn",    32'(rn_b),        32'd29);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("win_valid_%0d", i), 32'(out_valid_b), 32'h1);
            chk($sformatf("win_idx_%0d", i),   32'(out_idx_b),   32'(win_tbl[i].idx));
            chk($sformatf("win_data_%0d", i),  out_data_b,       win_tbl[i].data);
            if (i < 2) begin
                @(negedge clk);
                chk($sformatf("win_fetch_valid_%0d", i), 32'(out_valid_b), 32'h0);
            end
        end
        @(negedge clk);
        chk("win_done",       32'(done_b),      32'h1);
        chk("win_done_valid", 32'(out_valid_b), 32'h0);
        @(negedge clk);
        chk("win_after_busy", 32'(busy_b), 32'h0);
        chk("win_after_done", 32'(done_b), 32'h0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("win_nowrap_valid_%0d", c), 32'(out_valid_b), 32'h0);
        end
        chk("win_done_count", 32'(done_cnt_b), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
